uart_rx_core: RTL and testbench
===============================

UART_RX_CORE -- requirements
Module: uart_rx_core

Interface
REQ-001 SHALL have parameter CLK_DIV, default 163, meaning Clk cycles per oversample tick (range 2..8191).
REQ-002 SHALL have parameter OVERSAMPLE, default 16, meaning ticks per bit (even, 8..16).
REQ-003 SHALL have parameter DATA_BITS, default 8, meaning data bits per frame (5..9).
REQ-004 SHALL have parameter STOP_BITS, default 1, meaning stop bits checked (1 or 2).
REQ-005 SHALL have parameter FIFO_DEPTH, default 32, meaning receive FIFO entries (power of two, 2..256).
REQ-006 SHALL have port Clk, input, 1, the single clock; all state changes on its rising edge.
REQ-007 SHALL have port Reset, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port En, input, 1, receive enable.
REQ-009 SHALL have port RX, input, 1, serial line; idle high; asynchronous to Clk.
REQ-010 SHALL have port RD, input, 1, FIFO pop request.
REQ-011 SHALL have port data_out, output, DATA_BITS, FIFO head word (show-ahead).
REQ-012 SHALL have port valid, output, 1, FIFO non-empty.
REQ-013 SHALL have port full, output, 1, FIFO full.
REQ-014 SHALL have port count, output, $clog2(FIFO_DEPTH)+1, FIFO occupancy.
REQ-015 SHALL have ports FE, PE, OE, output, 1 each, one-cycle framing/parity/overrun error pulses.

Function
REQ-016 SHALL pass RX through a 2-flop synchroniser (reset value 1) before any use; start detection adds 2 cycles of latency.
REQ-017 SHALL generate a one-cycle tick every CLK_DIV cycles; the divider SHALL clear when the FSM leaves IDLE.
REQ-018 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP, BREAK.
REQ-019 IDLE->START on synchronised RX 1->0 while En=1.
REQ-020 START SHALL sample at tick OVERSAMPLE/2; 0 -> DATA, 1 -> IDLE (glitch rejected, no error).
REQ-021 DATA SHALL sample every OVERSAMPLE ticks, LSB first, DATA_BITS samples, then -> PARITY if enabled, else STOP.
REQ-022 STOP SHALL sample STOP_BITS bit-centres; any 0 -> FE pulse, word discarded, -> BREAK; all 1 -> push, -> IDLE.
REQ-023 BREAK SHALL wait for synchronised RX=1, then -> IDLE.
REQ-024 Push SHALL occur the cycle after the last stop sample; data_out/valid update the following cycle.
REQ-025 Push while full and no same-cycle pop SHALL pulse OE and drop the new word; FIFO contents unchanged.
REQ-026 Simultaneous push and pop SHALL both succeed, including when full; count unchanged.
REQ-027 RD while valid=0 SHALL be ignored; pointers wrap modulo FIFO_DEPTH.
REQ-028 En=0 SHALL force the FSM to IDLE next cycle, abandoning any partial frame; FIFO retained and RD still honoured.

Reset
REQ-029 Reset SHALL asynchronously set FSM=IDLE, divider=0, pointers=0, count=0, valid=0, full=0, FE=PE=OE=0, data_out=0.
REQ-030 Reset mid-frame SHALL discard the frame; no error pulse on release.

Configuration
REQ-031 With UART_RX_PARITY_EN defined, SHALL add parameter PARITY_ODD (default 0); PARITY state samples one bit, mismatch -> PE pulse and word discarded (FE takes priority if both).
REQ-032 Without UART_RX_PARITY_EN, PARITY state and PE logic SHALL be absent; PE tied 0.

Structure
REQ-033 Shared package uart_pkg SHALL hold the FSM state enum and parameter range limits.
REQ-034 SHALL instantiate one sub-module, uart_baud_tick (divider plus tick output, clear input).

Verification
REQ-035 CLK_DIV=4, OVERSAMPLE=16: frame 0xA5, 8N1 -> valid high, data_out=0xA5, count=1, no error pulses.
REQ-036 Stop bit driven 0 on 0x3C -> one FE pulse, count unchanged; FSM stays in BREAK until RX=1.
REQ-037 RX low pulse of 3 ticks -> no push, no error, FSM back in IDLE.
REQ-038 FIFO_DEPTH=4, 5 frames (0x01..0x05), no RD -> full=1, one OE pulse, pops return 0x01..0x04.
REQ-039 With UART_RX_PARITY_EN, PARITY_ODD=0: 0x07 with parity 0 -> PE pulse, dropped; with parity 1 -> pushed.
REQ-040 Reset asserted mid-DATA -> all outputs to reset values immediately; next clean 0x5A frame received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: state encoding and parameter limits shared by the UART receiver files.
package uart_pkg;

   // Fixed binary state codes; the enum below is built on them.
   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_PARITY = 3'd3;
   localparam logic [2:0] ST_STOP   = 3'd4;
   localparam logic [2:0] ST_BREAK  = 3'd5;

   typedef enum logic [2:0] {
      S_IDLE   = ST_IDLE,
      S_START  = ST_START,
      S_DATA   = ST_DATA,
      S_PARITY = ST_PARITY,
      S_STOP   = ST_STOP,
      S_BREAK  = ST_BREAK
   } uart_state_e;

   localparam int CLK_DIV_MIN    = 2;
   localparam int CLK_DIV_MAX    = 8191;
   localparam int OVERSAMPLE_MIN = 8;
   localparam int OVERSAMPLE_MAX = 16;
   localparam int DATA_BITS_MIN  = 5;
   localparam int DATA_BITS_MAX  = 9;
   localparam int STOP_BITS_MIN  = 1;
   localparam int STOP_BITS_MAX  = 2;
   localparam int FIFO_DEPTH_MIN = 2;
   localparam int FIFO_DEPTH_MAX = 256;

   function automatic bit in_range(input int v, input int lo, input int hi);
      return (v >= lo) && (v <= hi);
   endfunction

   function automatic bit is_pow2(input int v);
      return (v > 0) && ((v & (v - 1)) == 0);
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: oversample tick generator, one-cycle pulse every CLK_DIV clocks.
// clr reloads the divider so ticks are phase-aligned to the start edge.
module uart_baud_tick #(
   parameter int CLK_DIV = 163
) (
   input  logic Clk,
   input  logic Reset,
   input  logic clr,
   output logic tick
);

   localparam int            DW     = $clog2(CLK_DIV);
   localparam logic [DW-1:0] RELOAD = DW'(CLK_DIV - 1);

   logic [DW-1:0] div_cnt;

   // Down-counter; terminal count reloads and fires the tick.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         div_cnt <= '0;
         tick    <= 1'b0;
      end else if (clr) begin
         div_cnt <= RELOAD;
         tick    <= 1'b0;
      end else if (div_cnt == '0) begin
         div_cnt <= RELOAD;
         tick    <= 1'b1;
      end else begin
         div_cnt <= div_cnt - DW'(1);
         tick    <= 1'b0;
      end
   end

endmodule

// File: rtl/uart_rx_core.sv
// uart_rx_core: oversampling UART receiver feeding a show-ahead receive FIFO.
// Define UART_RX_PARITY_EN to build the parity bit check (adds PARITY_ODD);
// without it there is no PARITY state and PE is tied low.
//
// state  | meaning
// IDLE   | waiting for a synchronised 1->0 edge on RX
// START  | counting to the start-bit centre; high there means a glitch
// DATA   | sampling data bits LSB first at each bit centre
// PARITY | sampling the parity bit (parity builds only)
// STOP   | sampling stop bit(s); all high pushes the word
// BREAK  | framing error seen, waiting for RX to return high
module uart_rx_core
   import uart_pkg::*;
#(
   parameter int CLK_DIV    = 163,
   parameter int OVERSAMPLE = 16,
   parameter int DATA_BITS  = 8,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 32
`ifdef UART_RX_PARITY_EN
   ,
   parameter bit PARITY_ODD = 1'b0
`endif
) (
   input  logic                        Clk,
   input  logic                        Reset,
   input  logic                        En,
   input  logic                        RX,
   input  logic                        RD,
   output logic [DATA_BITS-1:0]        data_out,
   output logic                        valid,
   output logic                        full,
   output logic [$clog2(FIFO_DEPTH):0] count,
   output logic                        FE,
   output logic                        PE,
   output logic                        OE
);

   localparam int            TW        = $clog2(OVERSAMPLE);
   localparam int            AW        = $clog2(FIFO_DEPTH);
   localparam logic [AW:0]   DEPTH_CNT = (AW + 1)'(FIFO_DEPTH);
   localparam logic [TW-1:0] HALF_BIT  = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] FULL_BIT  = TW'(OVERSAMPLE - 1);

   localparam bit PARAMS_OK =
      in_range(CLK_DIV, CLK_DIV_MIN, CLK_DIV_MAX) &&
      in_range(OVERSAMPLE, OVERSAMPLE_MIN, OVERSAMPLE_MAX) && (OVERSAMPLE % 2 == 0) &&
      in_range(DATA_BITS, DATA_BITS_MIN, DATA_BITS_MAX) &&
      in_range(STOP_BITS, STOP_BITS_MIN, STOP_BITS_MAX) &&
      in_range(FIFO_DEPTH, FIFO_DEPTH_MIN, FIFO_DEPTH_MAX) && is_pow2(FIFO_DEPTH);

   if (!PARAMS_OK) begin : g_bad_params
      $error("uart_rx_core: parameter out of supported range");
   end

   uart_state_e          state;
   logic                 rx_meta, rx_s, rx_prev;
   logic                 tick, div_clr, sample_evt;
   logic [TW-1:0]        tcnt;
   logic [3:0]           bcnt;
   logic [DATA_BITS-1:0] shreg;
   logic                 push_req;
   logic                 fe_r, oe_r;
`ifdef UART_RX_PARITY_EN
   logic                 pe_r, par_bad;
`endif

   logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]        wr_ptr, rd_ptr;
   logic [AW:0]          fifo_cnt;
   logic                 pop, wr;

   // Divider is held clear while idle so the first tick is aligned to the start edge.
   assign div_clr    = (state == S_IDLE);
   assign sample_evt = tick && (tcnt == '0);

   uart_baud_tick #(.CLK_DIV(CLK_DIV)) u_baud_tick (
      .Clk   (Clk),
      .Reset (Reset),
      .clr   (div_clr),
      .tick  (tick)
   );

   // Two-flop synchroniser plus one delayed copy for edge detection.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= RX;
         rx_s    <= rx_meta;
         rx_prev <= rx_s;
      end
   end

   // Frame FSM with tick down-counter (bit-centre phase) and bit down-counter.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state    <= S_IDLE;
         tcnt     <= '0;
         bcnt     <= '0;
         shreg    <= '0;
         push_req <= 1'b0;
         fe_r     <= 1'b0;
`ifdef UART_RX_PARITY_EN
         pe_r     <= 1'b0;
         par_bad  <= 1'b0;
`endif
      end else begin
         push_req <= 1'b0;
         fe_r     <= 1'b0;
`ifdef UART_RX_PARITY_EN
         pe_r     <= 1'b0;
`endif
         if (tick) begin
            tcnt <= (tcnt == '0) ? FULL_BIT : tcnt - TW'(1);
         end
         if (!En) begin
            state <= S_IDLE;
         end else begin
            case (state)
               S_IDLE: begin
                  if (rx_prev && !rx_s) begin
                     state <= S_START;
                     tcnt  <= HALF_BIT;
`ifdef UART_RX_PARITY_EN
                     par_bad <= 1'b0;
`endif
                  end
               end
               S_START: begin
                  if (sample_evt) begin
                     if (rx_s) begin
                        state <= S_IDLE;
                     end else begin
                        state <= S_DATA;
                        bcnt  <= 4'(DATA_BITS - 1);
                     end
                  end
               end
               S_DATA: begin
                  if (sample_evt) begin
                     shreg <= {rx_s, shreg[DATA_BITS-1:1]};
                     if (bcnt == '0) begin
`ifdef UART_RX_PARITY_EN
                        state <= S_PARITY;
`else
                        state <= S_STOP;
                        bcnt  <= 4'(STOP_BITS - 1);
`endif
                     end else begin
                        bcnt <= bcnt - 4'd1;
                     end
                  end
               end
`ifdef UART_RX_PARITY_EN
               S_PARITY: begin
                  if (sample_evt) begin
                     par_bad <= rx_s ^ (^shreg) ^ PARITY_ODD;
                     state   <= S_STOP;
                     bcnt    <= 4'(STOP_BITS - 1);
                  end
               end
`endif
               S_STOP: begin
                  if (sample_evt) begin
                     if (!rx_s) begin
                        fe_r  <= 1'b1;
                        state <= S_BREAK;
                     end else if (bcnt == '0) begin
                        state <= S_IDLE;
`ifdef UART_RX_PARITY_EN
                        if (par_bad) pe_r <= 1'b1;
                        else         push_req <= 1'b1;
`else
                        push_req <= 1'b1;
`endif
                     end else begin
                        bcnt <= bcnt - 4'd1;
                     end
                  end
               end
               S_BREAK: begin
                  if (rx_s) state <= S_IDLE;
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

   // A push into a full FIFO only lands if the same cycle also pops.
   assign valid    = (fifo_cnt != '0);
   assign full     = (fifo_cnt == DEPTH_CNT);
   assign count    = fifo_cnt;
   assign pop      = RD && valid;
   assign wr       = push_req && (!full || pop);
   assign data_out = valid ? mem[rd_ptr] : '0;

   // FIFO pointers, occupancy and overrun pulse.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
         oe_r     <= 1'b0;
      end else begin
         oe_r <= push_req && !wr;
         if (wr)  wr_ptr <= wr_ptr + AW'(1);
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         if (wr && !pop)      fifo_cnt <= fifo_cnt + (AW + 1)'(1);
         else if (pop && !wr) fifo_cnt <= fifo_cnt - (AW + 1)'(1);
      end
   end

   // FIFO storage write.
   always_ff @(posedge Clk) begin
      if (wr) mem[wr_ptr] <= shreg;
   end

   assign FE = fe_r;
   assign OE = oe_r;
`ifdef UART_RX_PARITY_EN
   assign PE = pe_r;
`else
   assign PE = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: directed bench for uart_rx_core with a receive scoreboard.
module tb_uart_rx_core;
   import uart_pkg::*;

   localparam int BIT_CYC = 4 * 16;

   logic       Clk, Reset, En, RX, RD;
   logic [7:0] data_out;
   logic       valid, full, FE, PE, OE;
   logic [2:0] count;

   int tests  = 0;
   int failed = 0;
   int fe_cnt = 0, pe_cnt = 0, oe_cnt = 0;
   int fe0, pe0, oe0;
   logic [7:0] exp_q [$];

   uart_rx_core #(
      .CLK_DIV    (4),
      .OVERSAMPLE (16),
      .DATA_BITS  (8),
      .STOP_BITS  (1),
      .FIFO_DEPTH (4)
`ifdef UART_RX_PARITY_EN
      ,
      .PARITY_ODD (1'b0)
`endif
   ) dut (
      .Clk      (Clk),
      .Reset    (Reset),
      .En       (En),
      .RX       (RX),
      .RD       (RD),
      .data_out (data_out),
      .valid    (valid),
      .full     (full),
      .count    (count),
      .FE       (FE),
      .PE       (PE),
      .OE       (OE)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   always @(negedge Clk) begin
      if (FE === 1'b1) fe_cnt++;
      if (PE === 1'b1) pe_cnt++;
      if (OE === 1'b1) oe_cnt++;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      RX = 1'b1;
      repeat (n) @(negedge Clk);
   endtask

   task automatic send_bit(input logic b);
      RX = b;
      repeat (BIT_CYC) @(negedge Clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_v);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
      send_bit(^d);
`endif
      send_bit(stop_v);
   endtask

`ifdef UART_RX_PARITY_EN
   task automatic send_frame_par(input logic [7:0] d, input logic par);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
      send_bit(par);
      send_bit(1'b1);
   endtask
`endif

   task automatic pop_check(input string tag);
      int         n;
      logic [7:0] exp;
      n = 0;
      while (valid !== 1'b1 && n < 2000) begin
         @(negedge Clk);
         n++;
      end
      exp = 8'h00;
      if (exp_q.size() > 0) exp = exp_q.pop_front();
      tests++;
      assert (valid === 1'b1 && data_out === exp)
      else begin
         failed++;
         $error("FAIL %s: observed data_out=%h valid=%b expected data_out=%h valid=1",
                tag, data_out, valid, exp);
      end
      RD = 1'b1;
      @(negedge Clk);
      RD = 1'b0;
   endtask

   initial begin
      Reset = 1'b0; En = 1'b1; RX = 1'b1; RD = 1'b0;
      #2 Reset = 1'b1;
      #1;
      check("rst_valid", valid, 0);
      check("rst_full", full, 0);
      check("rst_count", count, 0);
      check("rst_data", data_out, 0);
      check("rst_fe", FE, 0);
      check("rst_pe", PE, 0);
      check("rst_oe", OE, 0);
      repeat (3) @(negedge Clk);
      Reset = 1'b0;
      idle(20);

      // Clean 0xA5 frame.
      fe0 = fe_cnt; pe0 = pe_cnt; oe0 = oe_cnt;
      exp_q.push_back(8'hA5);
      send_frame(8'hA5, 1'b1);
      idle(4);
      check("a5_valid", valid, 1);
      check("a5_data", data_out, 8'hA5);
      check("a5_count", count, 1);
      check("a5_no_err", (fe_cnt - fe0) + (pe_cnt - pe0) + (oe_cnt - oe0), 0);
      pop_check("a5_pop");
      check("a5_count_after_pop", count, 0);

      // Framing error with the line held low afterwards.
      fe0 = fe_cnt;
      send_frame(8'h3C, 1'b0);
      repeat (5 * BIT_CYC) @(negedge Clk);
      check("brk_fe_once", fe_cnt - fe0, 1);
      check("brk_count", count, 0);
      check("brk_state", dut.state, ST_BREAK);
      idle(6);
      check("brk_release", dut.state, ST_IDLE);

      // Three-tick glitch on the line.
      fe0 = fe_cnt; pe0 = pe_cnt; oe0 = oe_cnt;
      RX = 1'b0;
      repeat (12) @(negedge Clk);
      idle(2 * BIT_CYC);
      check("glitch_count", count, 0);
      check("glitch_no_err", (fe_cnt - fe0) + (pe_cnt - pe0) + (oe_cnt - oe0), 0);
      check("glitch_state", dut.state, ST_IDLE);

      // En dropped mid-frame abandons it; FIFO still pops while disabled.
      exp_q.push_back(8'h33);
      send_frame(8'h33, 1'b1);
      idle(2 * BIT_CYC);
      fe0 = fe_cnt;
      RX = 1'b0;
      repeat (2 * BIT_CYC) @(negedge Clk);
      En = 1'b0;
      pop_check("en0_pop");
      repeat (8) @(negedge Clk);
      En = 1'b1;
      repeat (8 * BIT_CYC) @(negedge Clk);
      idle(3 * BIT_CYC);
      check("en0_count", count, 0);
      check("en0_no_fe", fe_cnt - fe0, 0);

      // Overrun: five frames into a four-entry FIFO.
      oe0 = oe_cnt;
      for (int k = 1; k <= 5; k++) begin
         if (k <= 4) exp_q.push_back(8'(k));
         send_frame(8'(k), 1'b1);
         idle(2 * BIT_CYC);
      end
      check("ovr_full", full, 1);
      check("ovr_count", count, 4);
      check("ovr_oe_once", oe_cnt - oe0, 1);
      for (int k = 1; k <= 4; k++) pop_check("ovr_pop");
      check("ovr_drained", valid, 0);
      RD = 1'b1;
      @(negedge Clk);
      RD = 1'b0;
      check("empty_rd_count", count, 0);

`ifdef UART_RX_PARITY_EN
      pe0 = pe_cnt;
      send_frame_par(8'h07, 1'b0);
      idle(2 * BIT_CYC);
      check("par_pe_once", pe_cnt - pe0, 1);
      check("par_dropped", count, 0);
      exp_q.push_back(8'h07);
      send_frame_par(8'h07, 1'b1);
      idle(4);
      pop_check("par_ok_pop");
`else
      check("pe_tied_low", pe_cnt, 0);
`endif

      // Reset during DATA, then a clean frame.
      exp_q.push_back(8'h11);
      send_frame(8'h11, 1'b1);
      idle(2 * BIT_CYC);
      check("pre_rst_count", count, 1);
      fe0 = fe_cnt; pe0 = pe_cnt; oe0 = oe_cnt;
      RX = 1'b0;
      repeat (BIT_CYC + BIT_CYC / 2) @(negedge Clk);
      RX = 1'b1;
      repeat (BIT_CYC) @(negedge Clk);
      RX = 1'b0;
      repeat (BIT_CYC / 2) @(negedge Clk);
      Reset = 1'b1;
      #1;
      check("mid_rst_count", count, 0);
      check("mid_rst_valid", valid, 0);
      check("mid_rst_full", full, 0);
      check("mid_rst_data", data_out, 0);
      exp_q.delete();
      RX = 1'b1;
      repeat (3) @(negedge Clk);
      Reset = 1'b0;
      idle(3 * BIT_CYC);
      check("post_rst_no_err", (fe_cnt - fe0) + (pe_cnt - pe0) + (oe_cnt - oe0), 0);
      check("post_rst_count", count, 0);
      exp_q.push_back(8'h5A);
      send_frame(8'h5A, 1'b1);
      idle(4);
      check("5a_count", count, 1);
      pop_check("5a_pop");
      check("sb_empty", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
